// File: rtl/max_pkg.sv
// Shared types and constants for the serial max reducer.
// Holds the FSM state enum, the default slice width and the NSLICE helper.
package max_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  localparam int SLICE_DEF = 3;

  function automatic int calc_nslice(input int w, input int s);
    return w / s;
  endfunction

endpackage

// File: rtl/max_cmp_slice.sv
// One compare/select slice of the serial max reducer.
// Chains strictly-greater across slices, LSB-first, through carry_in.
module max_cmp_slice #(
  parameter int SLICE = 3
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             carry_in,
  output logic             gt_out
);

  // a beats b if this slice is larger, or equal with lower slices already larger
  always_comb begin
    gt_out = (a > b) | ((a == b) & carry_in);
  end

endmodule

// File: rtl/max_serial_reducer.sv
// Serial max/argmax reducer time-sharing one compare slice over the operand.
// Define MAX_ARGMAX_EN to track the argmax index and expose out_idx.
module max_serial_reducer
  import max_pkg::*;
#(
  parameter int W     = 12,
  parameter int SLICE = SLICE_DEF,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
  output logic [IDX_W-1:0] out_count
`ifdef MAX_ARGMAX_EN
  ,
  output logic [IDX_W-1:0] out_idx
`endif
);

  localparam int NSLICE = calc_nslice(W, SLICE);
  localparam int PW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NSLICE - 1);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  if (W % SLICE != 0) begin : g_bad_width
    $error("max_serial_reducer: W must be a multiple of SLICE");
  end

  state_t state_q, state_d;

  logic             first_q;
  logic             last_q;
  logic             carry_q;
  logic [PW-1:0]    ptr_q;
  logic [W-1:0]     max_q;
  logic [W-1:0]     cand_q;
  logic [IDX_W-1:0] cnt_q;
`ifdef MAX_ARGMAX_EN
  logic [IDX_W-1:0] idx_q;
`endif

  logic [NSLICE-1:0][SLICE-1:0] cand_v;
  logic [NSLICE-1:0][SLICE-1:0] max_v;
  logic gt;
  logic accept;
  logic last_slice;
  logic [IDX_W-1:0] cnt_inc;

  assign cand_v = cand_q;
  assign max_v  = max_q;

  max_cmp_slice #(
    .SLICE(SLICE)
  ) u_cmp (
    .a       (cand_v[ptr_q]),
    .b       (max_v[ptr_q]),
    .carry_in(carry_q),
    .gt_out  (gt)
  );

  assign accept     = in_valid & in_ready;
  assign last_slice = (state_q == CMP) && (ptr_q == PTR_LAST);
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + IDX_W'(1);

  assign out_max   = max_q;
  assign out_count = cnt_q;
`ifdef MAX_ARGMAX_EN
  assign out_idx   = idx_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (first_q) state_d = in_last ? DONE : IDLE;
          else         state_d = CMP;
        end
      end
      CMP: begin
        if (ptr_q == PTR_LAST) state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, slice walk and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      ptr_q   <= '0;
      max_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
`ifdef MAX_ARGMAX_EN
      idx_q   <= '0;
`endif
    end else begin
      if (accept) begin
        if (first_q) begin
          max_q   <= in_data;
          cnt_q   <= IDX_W'(1);
          first_q <= 1'b0;
`ifdef MAX_ARGMAX_EN
          idx_q   <= '0;
`endif
        end else begin
          cand_q  <= in_data;
          carry_q <= 1'b0;
          ptr_q   <= '0;
          last_q  <= in_last;
        end
      end
      if (state_q == CMP) begin
        carry_q <= gt;
        ptr_q   <= ptr_q + PW'(1);
        if (last_slice) begin
          ptr_q <= '0;
          cnt_q <= cnt_inc;
          if (gt) begin
            max_q <= cand_q;
`ifdef MAX_ARGMAX_EN
            idx_q <= cnt_q;
`endif
          end
        end
      end
      if (out_valid && out_ready) begin
        first_q <= 1'b1;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_max_serial_reducer.sv
// Randomized bench for max_serial_reducer against a queue-based model.
// Build with MAX_ARGMAX_EN defined to also check out_idx.
module tb_max_serial_reducer;

  localparam int W = 12;
  localparam int IDX_W = 8;
  localparam int NS = 4;
  localparam int SAT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_max;
  logic [IDX_W-1:0] out_count;
`ifdef MAX_ARGMAX_EN
  logic [IDX_W-1:0] out_idx;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  max_serial_reducer #(
    .W(W), .SLICE(3), .IDX_W(IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_count(out_count)
`ifdef MAX_ARGMAX_EN
    ,
    .out_idx  (out_idx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand at a negedge; returns cycles waited for in_ready.
  task automatic send(input logic [W-1:0] d, input logic l,
                      output int n);
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Send a whole packet, hold the result for `hold` cycles, then drain it.
  task automatic run_pkt(input logic [W-1:0] q[$], input int hold);
    logic [W-1:0] mx;
    int ix, cnt, n;
    mx = q[0];
    ix = 0;
    foreach (q[i]) if (q[i] > mx) begin
      mx = q[i];
      ix = i;
    end
    if (ix > SAT) ix = SAT;
    cnt = (q.size() > SAT) ? SAT : q.size();

    foreach (q[i]) begin
      send(q[i], i == q.size() - 1, n);
      chk("stall", n, (i >= 2) ? NS : 0);
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, (q.size() == 1) ? 0 : NS);
    for (int k = 0; k <= hold; k++) begin
      chk("out_valid", out_valid, 1);
      chk("out_max", out_max, mx);
      chk("out_count", out_count, cnt);
`ifdef MAX_ARGMAX_EN
      chk("out_idx", out_idx, ix);
`endif
      chk("ready_in_done", in_ready, 0);
      if (k < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained", out_valid, 0);
    chk("ready_after", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] q[$];
    int n;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    q = '{12'h5A3};
    run_pkt(q, 0);
    q = '{12'h100, 12'h7FF, 12'h200};
    run_pkt(q, 0);
    q = '{12'h3C3, 12'h3C3, 12'h0FF};
    run_pkt(q, 2);
    q = '{12'h001, 12'h800};
    run_pkt(q, 0);
    q = '{12'h400, 12'h123};
    run_pkt(q, 10);

    // asynchronous reset while the 2nd operand is being compared
    send(12'h0AA, 1'b0, n);
    send(12'hFFF, 1'b1, n);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_max", out_max, 0);
    chk("arst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{12'h010};
    run_pkt(q, 0);

    // random packets, some drawn from a tiny value set to force ties
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0)
          q.push_back(W'($urandom_range(0, 2) * 12'h7E1));
        else
          q.push_back(W'($urandom));
      end
      run_pkt(q, $urandom_range(0, 3));
    end

    // long packet: count and index saturate, winner sits past the limit
    q = {};
    for (int i = 0; i < 260; i++) q.push_back(W'($urandom_range(0, 12'hFF0)));
    q[100] = 12'hFF8;
    q[258] = 12'hFFF;
    run_pkt(q, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
